// File: rtl/index_adder_issuer.sv
// Issue/collect front end for the fixed-latency index adder wrapper.
// Optional ce/valid protocol check is built when INDEX_ADDER_ISSUER_CHECK_EN is defined.
module index_adder_issuer #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             adder_ce,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic             adder_valid,
  input  logic [WIDTH-1:0] adder_s,
  output logic             idle,
  output logic             err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] tag;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      inflight;
  logic               fire;
  logic               push;
  logic               pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(tag[i]);
    end
  end

  // Credits cover both queued results and sums still inside the adder, so a capture always has room.
  assign req_ready = (count + inflight) < CW'(DEPTH);
  assign fire      = req_valid && req_ready;
  assign adder_ce  = fire || (|tag[LATENCY-2:0]);
  assign adder_a   = req_a;
  assign adder_b   = req_b;

  assign push      = tag[LATENCY-1];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_s     = mem[rd_ptr];
  assign idle      = (tag == '0) && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      tag <= {tag[LATENCY-2:0], fire};
      if (push) begin
        mem[wr_ptr] <= adder_s;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef INDEX_ADDER_ISSUER_CHECK_EN
  // A capture slot without the wrapper's valid means the two pipelines disagree on latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (tag[LATENCY-1] && !adder_valid) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_adder_valid;
  assign unused_adder_valid = adder_valid;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_index_adder_issuer.sv
// Scoreboard bench for index_adder_issuer, with a behavioural ce-gated adder wrapper model.
module tb_index_adder_issuer;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

`ifdef INDEX_ADDER_ISSUER_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_s;
  logic             adder_ce;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_valid;
  logic [WIDTH-1:0] adder_s;
  logic             idle;
  logic             err;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] exp_q [$];
  int               pop_cyc [$];
  logic [WIDTH-1:0] mon_exp;
  logic             force_invalid = 1'b0;
  int               accepted;

  index_adder_issuer #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
    .adder_ce(adder_ce), .adder_a(adder_a), .adder_b(adder_b),
    .adder_valid(adder_valid), .adder_s(adder_s),
    .idle(idle), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper model: a LATENCY-deep pipeline that only advances while ce is high.
  logic [WIDTH-1:0]   pipe_s [LATENCY];
  logic [LATENCY-1:0] pipe_v = '0;
  initial for (int i = 0; i < LATENCY; i++) pipe_s[i] = '0;
  always @(posedge clk) begin
    if (adder_ce) begin
      pipe_s[0] <= adder_a + adder_b;
      pipe_v[0] <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_s[i] <= pipe_s[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end
  assign adder_s     = pipe_s[LATENCY-1];
  assign adder_valid = pipe_v[LATENCY-1] && !force_invalid;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expected sum.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got 0x%0h with no expected entry at cycle %0d", rsp_s, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("rsp_s", {16'h0, rsp_s}, {16'h0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until it fires; req_valid is left high so callers can stream.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] exp_s);
    bit done;
    done = 0;
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(exp_s);
        done = 1;
      end
      tick();
    end
    if (!done) check_output("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 50 && (exp_q.size() != 0 || !idle); n++) tick();
    check_output("drain_idle", {31'd0, idle}, 32'd1);
    check_output("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  logic [WIDTH-1:0] bp_a [4] = '{16'h1111, 16'h2222, 16'h7000, 16'hFFF0};
  logic [WIDTH-1:0] bp_b [4] = '{16'h0001, 16'h0002, 16'h9000, 16'h0020};
  logic [WIDTH-1:0] bp_e [4] = '{16'h1112, 16'h2224, 16'h0000, 16'h0010};

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("rst_rsp_s", {16'h0, rsp_s}, 32'h0);
    check_output("rst_adder_ce", {31'd0, adder_ce}, 32'd0);
    check_output("rst_idle", {31'd0, idle}, 32'd1);
    check_output("rst_err", {31'd0, err}, 32'd0);
    tick();
    rst = 1'b0;

    $display("[TB] single op latency");
    apply_stimulus(16'h0003, 16'h0004, 16'h0007);
    req_valid = 1'b0;
    @(negedge clk);
    check_output("single_ce_drain", {31'd0, adder_ce}, 32'd1);
    @(negedge clk);
    check_output("single_rsp_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_output("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("single_rsp_head", {16'h0, rsp_s}, 32'h0007);
    check_output("single_busy", {31'd0, idle}, 32'd0);
    check_output("single_ce_low", {31'd0, adder_ce}, 32'd0);
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check_output("single_idle_after_pop", {31'd0, idle}, 32'd1);
    check_output("single_rsp_gone", {31'd0, rsp_valid}, 32'd0);
    tick();

    $display("[TB] wrap-around sums");
    apply_stimulus(16'hFFFF, 16'h0001, 16'h0000);
    apply_stimulus(16'h8000, 16'h8000, 16'h0000);
    req_valid = 1'b0;
    wait_drain();

    $display("[TB] streaming");
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(WIDTH'(i), WIDTH'(2 * i), WIDTH'(3 * i));
    end
    req_valid = 1'b0;
    wait_drain();
    check_output("stream_count", pop_cyc.size(), 32'd16);
    if (pop_cyc.size() == 16) check_output("stream_no_bubbles", pop_cyc[15] - pop_cyc[0], 32'd15);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    accepted = 0;
    req_valid = 1'b1;
    req_a = bp_a[0];
    req_b = bp_b[0];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready) begin
        if (accepted < 4) exp_q.push_back(bp_e[accepted]);
        accepted++;
      end
      tick();
      if (accepted < 4) begin
        req_a = bp_a[accepted];
        req_b = bp_b[accepted];
      end
    end
    req_valid = 1'b0;
    check_output("bp_accepted", accepted, 32'd4);
    @(negedge clk);
    check_output("bp_full_ready", {31'd0, req_ready}, 32'd0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("bp_pop_same_cycle", {31'd0, req_ready}, 32'd0);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_output("bp_credit_back", {31'd0, req_ready}, 32'd1);
    tick();
    rsp_ready = 1'b1;
    wait_drain();

    $display("[TB] reset mid-flight");
    req_valid = 1'b1;
    req_a = 16'h0101;
    req_b = 16'h0202;
    tick();
    req_a = 16'h0303;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("rstmid_idle", {31'd0, idle}, 32'd1);
    check_output("rstmid_ce", {31'd0, adder_ce}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      check_output("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    tick();

    $display("[TB] protocol check");
    force_invalid = 1'b1;
    rsp_ready = 1'b0;
    apply_stimulus(16'h0005, 16'h0006, 16'h000B);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    check_output("err_set", {31'd0, err}, {31'd0, ERR_EXP});
    force_invalid = 1'b0;
    tick();
    rsp_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    check_output("err_sticky", {31'd0, err}, {31'd0, ERR_EXP});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("err_cleared", {31'd0, err}, 32'd0);

    check_output("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
